// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with a valid/ready handshake on both sides.
// Define MUL_SIGNED_EN to treat a and b as two's-complement operands.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   partial_next;
    logic [2*WIDTH-1:0]   result;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [CW-1:0]        count;
    logic                 last_step;

    assign last_step    = (count == CW'(WIDTH - 1));
    assign partial_next = partial + (mplier[0] ? mcand : '0);
    assign in_ready     = (state == IDLE);
    assign out_valid    = (state == DONE);

`ifdef MUL_SIGNED_EN
    logic negate;

    // Multiply magnitudes; the most negative value still fits as an unsigned magnitude.
    assign a_mag  = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign b_mag  = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign result = negate ? (~partial_next + 1'b1) : partial_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            negate <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            negate <= a[WIDTH-1] ^ b[WIDTH-1];
        end
    end
`else
    assign a_mag  = a;
    assign b_mag  = b;
    assign result = partial_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = CALC;
            CALC:    if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // product is only written on DONE entry, so it holds through DONE and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            partial <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand   <= {{WIDTH{1'b0}}, a_mag};
                        mplier  <= b_mag;
                        partial <= '0;
                        count   <= '0;
                    end
                end
                CALC: begin
                    partial <= partial_next;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    count   <= count + 1'b1;
                    if (last_step) begin
                        product <= result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized self-checking bench for seq_multiplier against a cycle-count reference model.
// Build with MUL_SIGNED_EN defined to exercise the two's-complement variant.
module tb_seq_multiplier;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;

    int checks = 0;
    int errors = 0;
    logic check_en;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        longint p;
`ifdef MUL_SIGNED_EN
        p = longint'($signed(x)) * longint'($signed(y));
`else
        p = longint'(x) * longint'(y);
`endif
        return p[2*W-1:0];
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: busy for exactly W edges after the accept edge, then holds its result until taken.
    logic           m_busy;
    logic           m_valid;
    int             m_left;
    logic [2*W-1:0] m_res;
    logic [2*W-1:0] m_prod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_left  <= 0;
            m_res   <= '0;
            m_prod  <= '0;
        end else if (m_valid) begin
            if (out_ready) m_valid <= 1'b0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b1;
                m_prod  <= m_res;
            end
            m_left <= m_left - 1;
        end else if (in_valid) begin
            m_busy <= 1'b1;
            m_left <= W;
            m_res  <= ref_mul(a, b);
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && check_en) begin
            check_output("in_ready", {31'd0, in_ready}, {31'd0, !(m_busy || m_valid)});
            check_output("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            check_output("product", {16'd0, product}, {16'd0, m_prod});
        end
    end

    // Downstream accumulator fed by the output handshake.
    logic        acc_clear;
    logic [15:0] acc;

    always @(posedge clk) begin
        if (acc_clear) acc <= '0;
        else if (out_valid && out_ready) acc <= acc + 16'(product);
    end

    // One complete operation: offer, accept, scramble ignored inputs during CALC, hold, handshake.
    task automatic apply_stimulus(input logic [W-1:0] x, input logic [W-1:0] y, input int hold,
                                  output logic [2*W-1:0] res, output int lat);
        int guard;
        @(negedge clk);
        a = x;
        b = y;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check_output("accept_timeout", 32'(guard), 32'd0);
        @(posedge clk);
        lat = 1;
        while (lat < 50) begin
            @(negedge clk);
            if (out_valid) break;
            in_valid = 1'($urandom_range(0, 1));
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk);
            lat++;
        end
        in_valid = 1'b0;
        if (lat >= 50) check_output("done_timeout", 32'(lat), 32'd9);
        repeat (hold) @(negedge clk);
        res = product;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [2*W-1:0] res;
        int             lat;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        check_en  = 1'b0;
        acc_clear = 1'b1;

        #12;
        check_output("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check_output("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check_output("reset_product", {16'd0, product}, 32'd0);

        @(negedge clk);
        #1;
        rst_n    = 1'b1;
        check_en = 1'b1;
        @(negedge clk);
        acc_clear = 1'b0;

        apply_stimulus(8'd13, 8'd11, 0, res, lat);
        check_output("mul_13x11", {16'd0, res}, 32'd143);
        check_output("latency_13x11", 32'(lat), 32'd9);

        // Abort an operation four CALC cycles in; outputs must clear without a clock edge.
        @(negedge clk);
        a = 8'd9;
        b = 8'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midcalc_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_output("midcalc_rst_product", {16'd0, product}, 32'd0);
        check_output("midcalc_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        apply_stimulus(8'd3, 8'd5, 0, res, lat);
        check_output("mul_3x5", {16'd0, res}, 32'd15);

        apply_stimulus(8'd0, 8'd200, 0, res, lat);
        check_output("mul_0x200", {16'd0, res}, 32'd0);
        check_output("latency_0x200", 32'(lat), 32'd9);
        check_output("accumulator_sum", {16'd0, acc}, 32'd158);

`ifdef MUL_SIGNED_EN
        apply_stimulus(8'hF9, 8'd6, 1, res, lat);
        check_output("smul_m7x6", {16'd0, res}, 32'hFFD6);
        apply_stimulus(8'h80, 8'h80, 0, res, lat);
        check_output("smul_m128xm128", {16'd0, res}, 32'h4000);
        check_output("latency_m128", 32'(lat), 32'd9);
        apply_stimulus(8'hFF, 8'hFF, 0, res, lat);
        check_output("smul_m1xm1", {16'd0, res}, 32'd1);
`else
        apply_stimulus(8'd255, 8'd255, 2, res, lat);
        check_output("mul_255x255", {16'd0, res}, 32'd65025);
`endif

        // Backpressure for 20 cycles, then an immediate back-to-back operation.
        apply_stimulus(8'd13, 8'd11, 20, res, lat);
        check_output("backpressure_product", {16'd0, res}, 32'd143);
        check_output("after_handshake_in_ready", {31'd0, in_ready}, 32'd1);
        check_output("after_handshake_out_valid", {31'd0, out_valid}, 32'd0);
        apply_stimulus(8'd21, 8'd4, 0, res, lat);
        check_output("mul_21x4", {16'd0, res}, 32'd84);
        check_output("latency_back_to_back", 32'(lat), 32'd9);

        for (int i = 0; i < 25; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            x = W'($urandom);
            y = W'($urandom);
            apply_stimulus(x, y, $urandom_range(0, 3), res, lat);
            check_output("random_product", {16'd0, res}, {16'd0, ref_mul(x, y)});
            check_output("random_latency", 32'(lat), 32'd9);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
